// File: rtl/soc_system_timer_sched_pkg.sv
// Shared definitions for the system timer scheduler: register map, STATUS bit
// positions and the scan FSM state type.
package soc_system_timer_sched_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_CHSEL   = 3'd2;
  localparam logic [2:0] ADDR_RELOAD  = 3'd3;
  localparam logic [2:0] ADDR_CHCTRL  = 3'd4;
  localparam logic [2:0] ADDR_COUNT   = 3'd5;

  localparam int BUSY_BIT = 14;
  localparam int OVR_BIT  = 15;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/soc_system_timer_sched_if.sv
// Avalon-MM slave bus of the timer scheduler (HPS lightweight bridge side).
// A write happens in any cycle with chipselect high and write_n low; readdata is
// the registered address mux and follows address with one cycle of latency.
interface soc_system_timer_sched_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/soc_system_timer_sched_chan_bank.sv
// Per-channel state (count, reload, enable, periodic) with one host write port
// and one scan read-modify-write port; a host write to the same channel wins.
module soc_system_timer_sched_chan_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       host_ch_i,
  input  logic             host_reload_we_i,
  input  logic             host_ctrl_we_i,
  input  logic [15:0]      host_wdata_i,
  input  logic [3:0]       scan_idx_i,
  input  logic             scan_we_i,
  input  logic [CNT_W-1:0] scan_count_i,
  input  logic             scan_clr_en_i,
  output logic [CNT_W-1:0] scan_count_o,
  output logic [CNT_W-1:0] scan_reload_o,
  output logic             scan_en_o,
  output logic             scan_per_o,
  output logic [CNT_W-1:0] rd_count_o,
  output logic [CNT_W-1:0] rd_reload_o,
  output logic             rd_en_o,
  output logic             rd_per_o
);

  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [CNT_W-1:0]  reload_q [NUM_CH];
  logic [CNT_W-1:0]  reload_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] per_q, per_d;

  always_comb begin
    scan_count_o  = '0;
    scan_reload_o = '0;
    scan_en_o     = 1'b0;
    scan_per_o    = 1'b0;
    rd_count_o    = '0;
    rd_reload_o   = '0;
    rd_en_o       = 1'b0;
    rd_per_o      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (scan_idx_i == 4'(i)) begin
        scan_count_o  = count_q[i];
        scan_reload_o = reload_q[i];
        scan_en_o     = en_q[i];
        scan_per_o    = per_q[i];
      end
      if (host_ch_i == 4'(i)) begin
        rd_count_o  = count_q[i];
        rd_reload_o = reload_q[i];
        rd_en_o     = en_q[i];
        rd_per_o    = per_q[i];
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    per_d    = per_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (scan_we_i && scan_idx_i == 4'(i)) begin
        count_d[i] = scan_count_i;
        if (scan_clr_en_i) en_d[i] = 1'b0;
      end
      if (host_reload_we_i && host_ch_i == 4'(i)) begin
        reload_d[i] = host_wdata_i[CNT_W-1:0];
      end
      // A CHCTRL write owns the count: load on enable 0->1, otherwise hold it.
      if (host_ctrl_we_i && host_ch_i == 4'(i)) begin
        en_d[i]  = host_wdata_i[0];
        per_d[i] = host_wdata_i[1];
        if (!en_q[i] && host_wdata_i[0]) count_d[i] = reload_q[i];
        else                             count_d[i] = count_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
      en_q  <= '0;
      per_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      per_q    <= per_d;
    end
  end

endmodule

// File: rtl/soc_system_timer_sched.sv
// Timer scheduler top: Avalon decode, read mux, tick edge detect, scan FSM,
// shared decrementer and status/IRQ logic over a bank of countdown channels.
module soc_system_timer_sched
  import soc_system_timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  soc_system_timer_sched_if.slave  bus,
  input  logic                     tick_in,
  output logic                     irq,
  output state_e                   dbg_state
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              tick_q, tick_pend_q, tick_pend_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic              ovr_q, ovr_d;
  logic [NUM_CH-1:0] ie_q, ie_d;
  logic              gie_q, gie_d;
  logic [3:0]        chsel_q, chsel_d;
  logic [15:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d;

  logic              wr_en, wr_status, sel_valid, tick_edge;
  logic              scan_active, ovr_set, expire;
  logic [NUM_CH-1:0] pend_set, status_clr;
  logic [CNT_W-1:0]  cur_count, cur_reload, step_count;
  logic              cur_en, cur_per;
  logic [CNT_W-1:0]  rd_count, rd_reload;
  logic              rd_en, rd_per;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wr_status = wr_en && bus.address == ADDR_STATUS;
  assign sel_valid = chsel_q < 4'(NUM_CH);
  assign tick_edge = tick_in & ~tick_q;

  soc_system_timer_sched_chan_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_bank (
    .clk              (clk),
    .reset            (reset),
    .host_ch_i        (chsel_q),
    .host_reload_we_i (wr_en && bus.address == ADDR_RELOAD && sel_valid),
    .host_ctrl_we_i   (wr_en && bus.address == ADDR_CHCTRL && sel_valid),
    .host_wdata_i     (bus.writedata),
    .scan_idx_i       (idx_q),
    .scan_we_i        (scan_active & cur_en),
    .scan_count_i     (step_count),
    .scan_clr_en_i    (expire & ~cur_per),
    .scan_count_o     (cur_count),
    .scan_reload_o    (cur_reload),
    .scan_en_o        (cur_en),
    .scan_per_o       (cur_per),
    .rd_count_o       (rd_count),
    .rd_reload_o      (rd_reload),
    .rd_en_o          (rd_en),
    .rd_per_o         (rd_per)
  );

  // Scan FSM: a tick arriving mid-scan is remembered once; a second one is lost.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tick_pend_d = tick_pend_q;
    scan_active = 1'b0;
    ovr_set     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick_edge || tick_pend_q) begin
          state_d     = SCAN;
          idx_d       = '0;
          tick_pend_d = 1'b0;
        end
      end
      SCAN: begin
        scan_active = 1'b1;
        if (tick_edge) begin
          if (tick_pend_q) ovr_set     = 1'b1;
          else             tick_pend_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (tick_pend_q || tick_edge) tick_pend_d = 1'b0;
          else                          state_d     = IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared decrementer for the channel visited this cycle.
  always_comb begin
    expire     = cur_count == '0;
    step_count = cur_count - CNT_W'(1);
    if (expire) step_count = cur_per ? cur_reload : cur_count;
    pend_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (scan_active && cur_en && expire && idx_q == 4'(i)) pend_set[i] = 1'b1;
    end
  end

  always_comb begin
    status_clr = wr_status ? bus.writedata[NUM_CH-1:0] : '0;
    pending_d  = (pending_q & ~status_clr) | pend_set;
    ovr_d      = (ovr_q & ~(wr_status & bus.writedata[OVR_BIT])) | ovr_set;
    ie_d       = ie_q;
    gie_d      = gie_q;
    chsel_d    = chsel_q;
    if (wr_en && bus.address == ADDR_CONTROL) begin
      ie_d  = bus.writedata[NUM_CH-1:0];
      gie_d = bus.writedata[15];
    end
    if (wr_en && bus.address == ADDR_CHSEL) chsel_d = bus.writedata[3:0];
    irq_d = gie_q & |(pending_q & ie_q);
  end

  always_comb begin
    readdata_d = '0;
    unique case (bus.address)
      ADDR_STATUS: begin
        readdata_d[NUM_CH-1:0] = pending_q;
        readdata_d[BUSY_BIT]   = state_q != IDLE;
        readdata_d[OVR_BIT]    = ovr_q;
      end
      ADDR_CONTROL: begin
        readdata_d[NUM_CH-1:0] = ie_q;
        readdata_d[15]         = gie_q;
      end
      ADDR_CHSEL:  readdata_d[3:0] = chsel_q;
      ADDR_RELOAD: if (sel_valid) readdata_d[CNT_W-1:0] = rd_reload;
      ADDR_CHCTRL: if (sel_valid) readdata_d[1:0] = {rd_per, rd_en};
      ADDR_COUNT:  if (sel_valid) readdata_d[CNT_W-1:0] = rd_count;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tick_q      <= 1'b0;
      tick_pend_q <= 1'b0;
      pending_q   <= '0;
      ovr_q       <= 1'b0;
      ie_q        <= '0;
      gie_q       <= 1'b0;
      chsel_q     <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tick_q      <= tick_in;
      tick_pend_q <= tick_pend_d;
      pending_q   <= pending_d;
      ovr_q       <= ovr_d;
      ie_q        <= ie_d;
      gie_q       <= gie_d;
      chsel_q     <= chsel_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_soc_system_timer_sched.sv
// Self-checking bench for soc_system_timer_sched (NUM_CH=4, CNT_W=16): register
// table, directed timing sequences and random ticks against a per-tick model.
module tb_soc_system_timer_sched;
  import soc_system_timer_sched_pkg::*;

  localparam int NCH = 4;

  logic   clk = 1'b0;
  logic   reset;
  logic   tick_in;
  logic   irq;
  state_e dbg_state;

  soc_system_timer_sched_if bus_if ();

  soc_system_timer_sched #(.NUM_CH(NCH), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .tick_in   (tick_in),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%04h want=0x%04h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [15:0] data);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    step();
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [15:0] data);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    step();
    data = bus_if.readdata;
    bus_idle();
  endtask

  task automatic read_check(input string name, input logic [2:0] addr, input logic [15:0] exp);
    logic [15:0] got;
    exp_q.push_back(exp);
    bus_read(addr, got);
    check(name, got, exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    tick_in = 1'b0;
    bus_if.address   = '0;
    bus_if.writedata = '0;
    bus_idle();
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dbg_state != IDLE && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got=busy want=idle");
    end
  endtask

  task automatic tick_wait();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
    wait_idle();
  endtask

  // ---------------- reference model: one call per processed tick ----------------
  int unsigned m_cnt [NCH];
  int unsigned m_rel [NCH];
  bit          m_en  [NCH];
  bit          m_per [NCH];
  logic [3:0]  m_pend;
  logic [3:0]  m_ie;
  bit          m_gie;

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_en[c] = 0; m_per[c] = 0;
    end
    m_pend = '0; m_ie = '0; m_gie = 0;
  endtask

  task automatic model_tick();
    for (int c = 0; c < NCH; c++) begin
      if (m_en[c]) begin
        if (m_cnt[c] == 0) begin
          m_pend[c] = 1'b1;
          if (m_per[c]) m_cnt[c] = m_rel[c];
          else          m_en[c]  = 0;
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [2:0]  addr;
    logic        do_wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } reg_vec_t;

  typedef struct {
    logic   tick;
    state_e exp_state;
  } seq_vec_t;

  reg_vec_t rv [18];
  seq_vec_t sv [10];

  initial begin
    logic [15:0] rd;

    for (int a = 0; a < 8; a++) rv[a] = '{3'(a), 1'b0, 16'h0000, 16'h0000};
    rv[8]  = '{ADDR_CHSEL,   1'b1, 16'h0002, 16'h0002};
    rv[9]  = '{ADDR_CHSEL,   1'b1, 16'h001F, 16'h000F};
    rv[10] = '{ADDR_CONTROL, 1'b1, 16'hFFFF, 16'h800F};
    rv[11] = '{3'd6,         1'b1, 16'h1234, 16'h0000};
    rv[12] = '{ADDR_CHSEL,   1'b1, 16'h0005, 16'h0005};
    rv[13] = '{ADDR_RELOAD,  1'b1, 16'hABCD, 16'h0000};
    rv[14] = '{ADDR_CHSEL,   1'b1, 16'h0003, 16'h0003};
    rv[15] = '{ADDR_RELOAD,  1'b1, 16'hABCD, 16'hABCD};
    rv[16] = '{ADDR_CHCTRL,  1'b1, 16'h0002, 16'h0002};
    rv[17] = '{ADDR_COUNT,   1'b1, 16'h0007, 16'h0000};

    // 1: reset values, then register write/readback table
    do_reset();
    check("reset_irq", {15'b0, irq}, 16'h0000);
    check("reset_state", {15'b0, dbg_state}, {15'b0, IDLE});
    for (int i = 0; i < 18; i++) begin
      if (rv[i].do_wr) bus_write(rv[i].addr, rv[i].wdata);
      read_check($sformatf("regvec%0d", i), rv[i].addr, rv[i].exp);
    end
    check("reg_irq", {15'b0, irq}, 16'h0000);

    // 2: ch0 periodic reload=2, expiry timing and W1C
    do_reset();
    bus_write(ADDR_CHSEL, 16'h0000);
    bus_write(ADDR_RELOAD, 16'h0002);
    bus_write(ADDR_CHCTRL, 16'h0003);
    bus_write(ADDR_CONTROL, 16'h8001);
    tick_wait();
    tick_wait();
    bus_if.address = ADDR_STATUS;
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
    check("t2_status_before", bus_if.readdata & 16'h0001, 16'h0000);
    check("t2_irq_before", {15'b0, irq}, 16'h0000);
    step();
    check("t2_status_set", bus_if.readdata & 16'h0001, 16'h0001);
    check("t2_irq_set", {15'b0, irq}, 16'h0001);
    wait_idle();
    bus_write(ADDR_STATUS, 16'h0001);
    step();
    check("t2_irq_cleared", {15'b0, irq}, 16'h0000);
    read_check("t2_status_cleared", ADDR_STATUS, 16'h0000);
    repeat (3) tick_wait();
    read_check("t2_status_again", ADDR_STATUS, 16'h0001);
    check("t2_irq_again", {15'b0, irq}, 16'h0001);

    // 3: ch1 one-shot reload=0
    bus_write(ADDR_STATUS, 16'h000F);
    bus_write(ADDR_CHSEL, 16'h0001);
    bus_write(ADDR_RELOAD, 16'h0000);
    bus_write(ADDR_CHCTRL, 16'h0001);
    tick_wait();
    read_check("t3_status", ADDR_STATUS, 16'h0002);
    read_check("t3_chctrl", ADDR_CHCTRL, 16'h0000);
    bus_write(ADDR_STATUS, 16'h0002);
    tick_wait();
    read_check("t3_no_repend", ADDR_STATUS, 16'h0000);
    bus_write(ADDR_CHSEL, 16'h0000);
    read_check("t3_ch0_count", ADDR_COUNT, 16'h0000);

    // 4: back-to-back scan, then overrun
    do_reset();
    sv[0] = '{1'b1, SCAN}; sv[1] = '{1'b0, SCAN}; sv[2] = '{1'b1, SCAN};
    sv[3] = '{1'b0, SCAN}; sv[4] = '{1'b0, SCAN}; sv[5] = '{1'b0, SCAN};
    sv[6] = '{1'b0, SCAN}; sv[7] = '{1'b0, SCAN}; sv[8] = '{1'b0, IDLE};
    sv[9] = '{1'b0, IDLE};
    for (int i = 0; i < 10; i++) begin
      tick_in = sv[i].tick;
      step();
      check($sformatf("t4_b2b_state%0d", i), {15'b0, dbg_state}, {15'b0, sv[i].exp_state});
    end
    read_check("t4_no_overrun", ADDR_STATUS, 16'h0000);
    sv[4] = '{1'b1, SCAN};
    for (int i = 0; i < 10; i++) begin
      tick_in = sv[i].tick;
      step();
      check($sformatf("t4_ovr_state%0d", i), {15'b0, dbg_state}, {15'b0, sv[i].exp_state});
    end
    tick_in = 1'b0;
    read_check("t4_overrun", ADDR_STATUS, 16'h8000);
    bus_write(ADDR_STATUS, 16'h8000);
    read_check("t4_overrun_clr", ADDR_STATUS, 16'h0000);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    read_check("t4_busy", ADDR_STATUS, 16'h4000);
    wait_idle();

    // 5: W1C in the expiring scan cycle loses to the set
    do_reset();
    bus_write(ADDR_RELOAD, 16'h0000);
    bus_write(ADDR_CHCTRL, 16'h0003);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    bus_write(ADDR_STATUS, 16'h0001);
    wait_idle();
    read_check("t5_set_wins", ADDR_STATUS, 16'h0001);

    // 6: reset in the idx=2 scan cycle
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      bus_write(ADDR_CHSEL, 16'(c));
      bus_write(ADDR_RELOAD, 16'(c));
      bus_write(ADDR_CHCTRL, 16'h0003);
    end
    bus_write(ADDR_CONTROL, 16'h800F);
    tick_wait();
    check("t6_irq_pre", {15'b0, irq}, 16'h0001);
    bus_if.address = ADDR_STATUS;
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("t6_state", {15'b0, dbg_state}, {15'b0, IDLE});
    check("t6_irq", {15'b0, irq}, 16'h0000);
    check("t6_readdata", bus_if.readdata, 16'h0000);
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      bus_write(ADDR_CHSEL, 16'(c));
      read_check($sformatf("t6_count%0d", c), ADDR_COUNT, 16'h0000);
    end
    read_check("t6_status", ADDR_STATUS, 16'h0000);

    // 7: random configuration, W1C and ticks against the per-tick model
    do_reset();
    model_clear();
    for (int r = 0; r < 80; r++) begin
      int op;
      int c;
      logic [15:0] v;
      op = $urandom_range(0, 9);
      c  = $urandom_range(0, NCH - 1);
      if (op <= 1) begin
        v = 16'($urandom_range(0, 3));
        m_rel[c] = $urandom_range(0, 4);
        bus_write(ADDR_CHSEL, 16'(c));
        bus_write(ADDR_RELOAD, 16'(m_rel[c]));
        bus_write(ADDR_CHCTRL, v);
        if (!m_en[c] && v[0]) m_cnt[c] = m_rel[c];
        m_en[c]  = v[0];
        m_per[c] = v[1];
      end else if (op == 2) begin
        m_ie  = 4'($urandom_range(0, 15));
        m_gie = 1'($urandom_range(0, 1));
        bus_write(ADDR_CONTROL, {m_gie, 11'b0, m_ie});
      end else if (op == 3) begin
        v = 16'($urandom_range(0, 15));
        bus_write(ADDR_STATUS, v);
        m_pend = m_pend & ~v[3:0];
      end else if (op <= 8) begin
        tick_wait();
        model_tick();
      end else begin
        read_check($sformatf("rnd%0d_status", r), ADDR_STATUS, {12'b0, m_pend});
        check($sformatf("rnd%0d_irq", r), {15'b0, irq}, {15'b0, m_gie & |(m_pend & m_ie)});
        bus_write(ADDR_CHSEL, 16'(c));
        read_check($sformatf("rnd%0d_count", r), ADDR_COUNT, 16'(m_cnt[c]));
        read_check($sformatf("rnd%0d_chctrl", r), ADDR_CHCTRL, {14'b0, m_per[c], m_en[c]});
      end
    end
    read_check("rnd_final_status", ADDR_STATUS, {12'b0, m_pend});
    for (int c = 0; c < NCH; c++) begin
      bus_write(ADDR_CHSEL, 16'(c));
      read_check($sformatf("rnd_final_count%0d", c), ADDR_COUNT, 16'(m_cnt[c]));
      read_check($sformatf("rnd_final_reload%0d", c), ADDR_RELOAD, 16'(m_rel[c]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
